controller_poller: RTL and testbench
====================================

CONTROLLER_POLLER -- requirements
Module: controller_poller

Interface
REQ-001 Parameter CLK_DIV, default 300, SHALL set the clk cycles per pad-clock half-phase (6 us at 50 MHz); legal values SHALL be >= 4.
REQ-002 Parameter AUTO_PERIOD, default 0, SHALL set the auto-poll interval in clk cycles; 0 SHALL disable auto-poll.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 poll_req  input  1  processor poll request (driven from cnt_int); level is sampled every cycle.
REQ-006 pad_data  input  1  serial data from the gamepad; active-low (0 = pressed); asynchronous to clk.
REQ-007 pad_latch  output  1  gamepad latch strobe, active-high.
REQ-008 pad_pulse  output  1  gamepad shift clock, active-high.
REQ-009 controller_data  output  8  button state, active-high (1 = pressed); feeds the processor's controller_data input.
REQ-010 data_valid  output  1  single-cycle pulse when controller_data is updated.
REQ-011 changed  output  1  single-cycle pulse, coincident with data_valid, when the new byte differs from the previous byte.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 pad_data SHALL pass through a 2-flop synchronizer before use; all sampling SHALL use the synchronized value.
REQ-014 The FSM SHALL have the states IDLE, LATCH, PULSE_HI, PULSE_LO and DONE.
REQ-015 IDLE: when a request is present (poll_req high, pending flag set, or auto-poll tick), the FSM SHALL enter LATCH on the next cycle and clear the pending flag.
REQ-016 LATCH SHALL last 2*CLK_DIV cycles with pad_latch=1; in the last LATCH cycle, the inverted synchronized pad_data SHALL be shifted into bit 0.
REQ-017 PULSE_HI SHALL last CLK_DIV cycles with pad_pulse=1.
REQ-018 PULSE_LO SHALL last CLK_DIV cycles with pad_pulse=0; its last cycle SHALL sample bit k (k=1..7, in order).
REQ-019 The FSM SHALL execute seven PULSE_HI/PULSE_LO pairs; after the pair for bit 7 it SHALL go to DONE.
REQ-020 Bit map: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
REQ-021 The shift register SHALL be internal; controller_data SHALL change only in DONE, so a partial byte is never visible.
REQ-022 DONE SHALL last one cycle: load controller_data, pulse data_valid, pulse changed if the new byte != the old byte, then return to IDLE.
REQ-023 Latency SHALL be exactly 16*CLK_DIV+2 cycles from the cycle poll_req is sampled high in IDLE to the data_valid cycle.
REQ-024 pad_latch and pad_pulse SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-025 A request arriving while busy=1 (poll_req or auto-poll tick) SHALL set a one-deep pending flag; further requests while it is set SHALL be dropped.
REQ-026 A request arriving in the DONE cycle SHALL also set the pending flag.
REQ-027 The auto-poll counter SHALL run freely from reset, tick at count AUTO_PERIOD-1, and wrap to 0.
REQ-028 The phase counter SHALL be wide enough for 2*CLK_DIV-1 and SHALL reset to 0 at every state entry.

Reset
REQ-029 When reset=0, the following SHALL apply immediately and asynchronously: state=IDLE; controller_data=8'h00; pad_latch, pad_pulse, data_valid, changed and busy =0; pending flag, shift register and both counters =0; synchronizer flops =1 (released).
REQ-030 Reset asserted mid-poll SHALL abort the poll with no data_valid pulse; after release the block SHALL wait for a new request.

Structure
REQ-031 The FSM state encodings and the button-index constants SHALL live in the shared package ctrl_pkg.
REQ-032 The synchronizer SHALL be a separate sub-module named sync2 (1-bit, reset value parameter).
REQ-033 The target size is 150-250 lines of RTL, excluding ctrl_pkg.

Verification (CLK_DIV=4, AUTO_PERIOD=0 unless stated)
REQ-034 Pad model returns 8'b0111_1110 (A and Right pressed, serial LSB first, active-low); 1-cycle poll_req -> data_valid at cycle 66, controller_data=8'h81, changed=1, pad_latch high for exactly 8 cycles, then 7 pad_pulse pulses of 4 cycles each.
REQ-035 Repeat the same poll -> controller_data=8'h81, data_valid=1, changed=0.
REQ-036 poll_req pulsed at cycles 10 and 20 and in the DONE cycle -> exactly two polls back-to-back, second starting the cycle after DONE; third request dropped.
REQ-037 reset=0 during the 3rd PULSE_HI -> all outputs 0 that cycle, no data_valid, controller_data stays 8'h00 until a new poll.
REQ-038 AUTO_PERIOD=100, poll_req tied low -> LATCH entered every 100 cycles; data_valid count = floor(1000/100) over 1000 cycles.
REQ-039 Assertions held throughout: !(pad_latch && pad_pulse); data_valid only the cycle after busy's last high cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the gamepad poller: FSM encoding and button bit positions.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LATCH    = 3'd1,
      ST_PULSE_HI = 3'd2,
      ST_PULSE_LO = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int unsigned NUM_BTNS  = 8;
   localparam int unsigned BIT_IDX_W = 3;

   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/controller_poller.sv
// Polls a serial gamepad (latch + 7 shift pulses) and presents the 8 button bits active-high.
module controller_poller
   import ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 300,
   parameter int unsigned AUTO_PERIOD = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                poll_req,
   input  logic                pad_data,
   output logic                pad_latch,
   output logic                pad_pulse,
   output logic [NUM_BTNS-1:0] controller_data,
   output logic                data_valid,
   output logic                changed,
   output logic                busy
);

   localparam int unsigned PH_W = $clog2(2 * CLK_DIV);
   localparam int unsigned AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(CLK_DIV - 1);

   state_t                 state, state_n;
   logic [PH_W-1:0]        phase;
   logic [BIT_IDX_W-1:0]   bit_idx;
   logic [NUM_BTNS-1:0]    shreg;
   logic                   pending;
   logic                   pad_s;
   logic                   auto_tick;
   logic                   req;
   logic                   sample;
   logic                   latch_n, pulse_n, busy_n;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pad_data),
      .q     (pad_s)
   );

   // Free-running auto-poll interval counter; absent when AUTO_PERIOD is 0.
   generate
      if (AUTO_PERIOD == 0) begin : g_no_auto
         assign auto_tick = 1'b0;
      end else begin : g_auto
         logic [AP_W-1:0] auto_cnt;
         assign auto_tick = (auto_cnt == AP_W'(AUTO_PERIOD - 1));
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)         auto_cnt <= '0;
            else if (auto_tick) auto_cnt <= '0;
            else                auto_cnt <= auto_cnt + AP_W'(1);
         end
      end
   endgenerate

   assign req = poll_req | auto_tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      sample  = 1'b0;
      case (state)
         ST_IDLE:     if (req || pending) state_n = ST_LATCH;
         ST_LATCH:    if (phase == LATCH_LAST) begin
                         state_n = ST_PULSE_HI;
                         sample  = 1'b1;
                      end
         ST_PULSE_HI: if (phase == HALF_LAST) state_n = ST_PULSE_LO;
         ST_PULSE_LO: if (phase == HALF_LAST) begin
                         sample  = 1'b1;
                         state_n = (bit_idx == BIT_IDX_W'(BTN_RIGHT)) ? ST_DONE : ST_PULSE_HI;
                      end
         ST_DONE:     state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
      latch_n = (state_n == ST_LATCH);
      pulse_n = (state_n == ST_PULSE_HI);
      busy_n  = (state_n != ST_IDLE);
   end

   // Datapath: phase timer, bit index, shift register, pending flag and outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase           <= '0;
         bit_idx         <= '0;
         shreg           <= '0;
         pending         <= 1'b0;
         pad_latch       <= 1'b0;
         pad_pulse       <= 1'b0;
         busy            <= 1'b0;
         data_valid      <= 1'b0;
         changed         <= 1'b0;
         controller_data <= '0;
      end else begin
         if (state_n != state || state == ST_IDLE) phase <= '0;
         else                                      phase <= phase + PH_W'(1);

         if (state == ST_LATCH)                            bit_idx <= BIT_IDX_W'(1);
         else if (state == ST_PULSE_LO && phase == HALF_LAST) bit_idx <= bit_idx + BIT_IDX_W'(1);

         // Pad data is active-low; bits enter at the top and walk down to their slot.
         if (sample) shreg <= {~pad_s, shreg[NUM_BTNS-1:1]};

         pending    <= (state != ST_IDLE) && (pending || req);
         pad_latch  <= latch_n;
         pad_pulse  <= pulse_n;
         busy       <= busy_n;
         data_valid <= (state == ST_DONE);
         changed    <= (state == ST_DONE) && (shreg != controller_data);
         if (state == ST_DONE) controller_data <= shreg;
      end
   end

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench for controller_poller with a shift-register gamepad model.
module tb_controller_poller;
   import ctrl_pkg::*;

   localparam int unsigned DIV = 4;
   localparam int unsigned LAT = 16 * DIV + 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       poll_req = 1'b0;
   logic       pad_data;
   logic       pad_latch, pad_pulse, data_valid, changed, busy;
   logic [7:0] controller_data;

   logic       a_latch, a_pulse, a_valid, a_changed, a_busy;
   logic [7:0] a_data;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   controller_poller #(.CLK_DIV(DIV), .AUTO_PERIOD(0)) dut (
      .clk(clk), .reset(reset), .poll_req(poll_req), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_pulse(pad_pulse), .controller_data(controller_data),
      .data_valid(data_valid), .changed(changed), .busy(busy));

   controller_poller #(.CLK_DIV(DIV), .AUTO_PERIOD(100)) u_auto (
      .clk(clk), .reset(reset), .poll_req(1'b0), .pad_data(1'b1),
      .pad_latch(a_latch), .pad_pulse(a_pulse), .controller_data(a_data),
      .data_valid(a_valid), .changed(a_changed), .busy(a_busy));

   // Gamepad model: parallel load while latched, shift toward bit 0 on each pulse rising edge.
   logic [7:0] pad_pattern = 8'h7E;
   logic [7:0] pad_sr = 8'hFF;
   logic       pulse_prev = 1'b0;
   always @(posedge clk) begin
      if (pad_latch)                   pad_sr <= pad_pattern;
      else if (pad_pulse && !pulse_prev) pad_sr <= {1'b1, pad_sr[7:1]};
      pulse_prev <= pad_pulse;
   end
   assign pad_data = pad_sr[0];

   // Continuous checks plus strobe bookkeeping on the falling edge.
   int   latch_cnt = 0, pulse_cnt = 0, pulse_w = 0, w_min = 1000, w_max = 0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      total++;
      assert (!(pad_latch && pad_pulse)) else begin
         bad++;
         $error("FAIL latch_pulse_overlap observed=%b%b expected=not_both", pad_latch, pad_pulse);
      end
      if (data_valid) begin
         total++;
         assert (busy_prev === 1'b1 && busy === 1'b0) else begin
            bad++;
            $error("FAIL valid_after_busy observed=%b%b expected=10", busy_prev, busy);
         end
      end
      if (pad_latch) latch_cnt++;
      if (pad_pulse) pulse_w++;
      else if (pulse_w != 0) begin
         pulse_cnt++;
         if (pulse_w < w_min) w_min = pulse_w;
         if (pulse_w > w_max) w_max = pulse_w;
         pulse_w = 0;
      end
      busy_prev = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_poll(input string tag, input logic [7:0] pattern,
                          input logic [7:0] exp_data, input logic exp_chg);
      int lat;
      bit seen;
      pad_pattern = pattern;
      latch_cnt = 0; pulse_cnt = 0; w_min = 1000; w_max = 0;
      lat = 0; seen = 0;
      poll_req = 1'b1;
      while (!seen && lat < 200) begin
         tick();
         poll_req = 1'b0;
         lat++;
         if (data_valid) seen = 1;
      end
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      check({tag, "_data"}, 32'(controller_data), 32'(exp_data));
      check({tag, "_changed"}, 32'(changed), 32'(exp_chg));
      check({tag, "_latch_cycles"}, 32'(latch_cnt), 32'd8);
      check({tag, "_pulse_count"}, 32'(pulse_cnt), 32'd7);
      check({tag, "_pulse_wmin"}, 32'(w_min), 32'(DIV));
      check({tag, "_pulse_wmax"}, 32'(w_max), 32'(DIV));
      tick();
      check({tag, "_valid_single"}, 32'({data_valid, changed}), 32'd0);
      check({tag, "_data_hold"}, 32'(controller_data), 32'(exp_data));
   endtask

   localparam logic [7:0] EXP_AR  = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
   localparam logic [7:0] EXP_BSUL = 8'((1 << BTN_B) | (1 << BTN_START) | (1 << BTN_UP) | (1 << BTN_LEFT));
   localparam logic [7:0] EXP_SD  = 8'((1 << BTN_SELECT) | (1 << BTN_DOWN));

   initial begin
      int dv_n, dv_c0, dv_c1, cnt, busy_cnt, chg_cnt, overlap, first_rise, interval;
      logic chg0, chg1, busy66, busy67, pulse_at_reset, prev_latch;

      // Reset state
      #1 reset = 1'b0;
      tick(); tick(); tick();
      check("reset_outputs", 32'({pad_latch, pad_pulse, data_valid, changed, busy}), 32'd0);
      check("reset_data", 32'(controller_data), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("idle_after_reset", 32'({busy, pad_latch, data_valid}), 32'd0);

      // Single polls with different button patterns
      do_poll("poll1", 8'b0111_1110, 8'h81, 1'b1);
      check("poll1_const", 32'(controller_data), 32'(EXP_AR));
      do_poll("poll2", 8'b0111_1110, 8'h81, 1'b0);
      do_poll("poll3", 8'hA5, 8'h5A, 1'b1);
      check("poll3_const", 32'(controller_data), 32'(EXP_BSUL));
      do_poll("poll4", 8'hDB, 8'h24, 1'b1);
      check("poll4_const", 32'(controller_data), 32'(EXP_SD));

      // Back-to-back: requests at cycles 10, 20 and in DONE
      pad_pattern = 8'h7E;
      dv_n = 0; dv_c0 = 0; dv_c1 = 0; chg0 = 0; chg1 = 0; busy66 = 1; busy67 = 0;
      poll_req = 1'b1;
      for (int c = 0; c < 300; c++) begin
         tick();
         poll_req = (c == 9 || c == 19 || c == 64);
         if (c == 65) busy66 = busy;
         if (c == 66) busy67 = busy;
         if (data_valid) begin
            if (dv_n == 0) begin dv_c0 = c + 1; chg0 = changed; end
            if (dv_n == 1) begin dv_c1 = c + 1; chg1 = changed; end
            dv_n++;
         end
      end
      poll_req = 1'b0;
      check("b2b_valid_count", 32'(dv_n), 32'd2);
      check("b2b_first_cycle", 32'(dv_c0), 32'(LAT));
      check("b2b_second_cycle", 32'(dv_c1), 32'(2 * LAT));
      check("b2b_changed", 32'({chg0, chg1}), 32'b10);
      check("b2b_busy_gap", 32'({busy66, busy67}), 32'b01);
      check("b2b_data", 32'(controller_data), 32'h81);

      // Reset during the third PULSE_HI
      poll_req = 1'b1;
      for (int c = 0; c < 26; c++) begin
         tick();
         poll_req = 1'b0;
      end
      pulse_at_reset = pad_pulse;
      check("mid_in_pulse_hi", 32'(pulse_at_reset), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_reset_outputs", 32'({pad_latch, pad_pulse, data_valid, changed, busy}), 32'd0);
      check("mid_reset_data", 32'(controller_data), 32'd0);
      tick(); tick(); tick();
      reset = 1'b1;
      cnt = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (data_valid) cnt++;
      end
      check("mid_no_valid", 32'(cnt), 32'd0);
      check("mid_data_held", 32'(controller_data), 32'd0);
      check("mid_idle", 32'(busy), 32'd0);
      do_poll("post_reset", 8'b0111_1110, 8'h81, 1'b1);

      // Auto-poll instance over a 1000-cycle window
      cnt = 0; busy_cnt = 0; chg_cnt = 0; overlap = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (a_valid) cnt++;
         if (a_busy) busy_cnt++;
         if (a_changed) chg_cnt++;
         if (a_latch && a_pulse) overlap++;
      end
      check("auto_valid_count", 32'(cnt), 32'd10);
      check("auto_busy_cycles", 32'(busy_cnt), 32'd650);
      check("auto_changed_count", 32'(chg_cnt), 32'd0);
      check("auto_overlap", 32'(overlap), 32'd0);
      check("auto_data", 32'(a_data), 32'd0);
      first_rise = -1; interval = 0; prev_latch = a_latch;
      for (int c = 0; c < 300 && interval == 0; c++) begin
         tick();
         if (a_latch && !prev_latch) begin
            if (first_rise < 0) first_rise = c;
            else interval = c - first_rise;
         end
         prev_latch = a_latch;
      end
      check("auto_latch_interval", 32'(interval), 32'd100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
